register_file_mp: RTL and testbench

Parametrised multi-port register file for the next-generation RISC V core, intended for pipelined and dual-issue datapaths. It generalises the single-cycle register file with:
- configurable numbers of read and write ports;
- synchronous reset;
- optional same-cycle write-to-read bypass;
- a per-register busy scoreboard that tracks outstanding writes.

It sits between decode, which reads operands and reserves destinations, and writeback, which commits results.

---
 rtl/register_file_mp_pkg.sv | 10 +
 rtl/register_file_mp_scoreboard.sv | 60 ++++++
 rtl/register_file_mp.sv | 91 +++++++++
 tb/tb_register_file_mp.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/register_file_mp_pkg.sv
// Shared defaults for the integer register file and its scoreboard.
// Register 0 is the hardwired zero register.
package rf_defs;

  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_REG_ADDR   = 5;
  localparam int RF_REG_CNT    = 32;
  localparam int ZERO_REG      = 0;

endpackage : rf_defs

// File: rtl/register_file_mp_scoreboard.sv
// Busy-bit scoreboard: reservations set bits, writebacks clear them, and a
// registered population count is maintained incrementally.
module rf_scoreboard
  import rf_defs::*;
#(
  parameter int REG_ADDR = RF_REG_ADDR,
  parameter int REG_CNT  = RF_REG_CNT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rsv_en,
  input  logic [REG_ADDR-1:0] rsv_addr,
  input  logic [REG_CNT-1:0]  clr_vec,
  output logic [REG_CNT-1:0]  busy,
  output logic [REG_ADDR:0]   busy_cnt
);

  localparam logic [REG_ADDR:0] CNT_ONE = {{REG_ADDR{1'b0}}, 1'b1};

  logic [REG_CNT-1:0] busy_q, busy_d;
  logic [REG_CNT-1:0] set_vec;
  logic [REG_ADDR:0]  busy_cnt_q, busy_cnt_d;

  // A same-cycle reservation outranks the clear: it belongs to a younger producer.
  always_comb begin
    set_vec = '0;
    for (int i = 1; i < REG_CNT; i++) begin
      if (rsv_en && rsv_addr == REG_ADDR'(i)) begin
        set_vec[i] = 1'b1;
      end
    end

    busy_d           = (busy_q & ~clr_vec) | set_vec;
    busy_d[ZERO_REG] = 1'b0;

    busy_cnt_d = busy_cnt_q;
    if (|(set_vec & ~busy_q)) begin
      busy_cnt_d = busy_cnt_d + CNT_ONE;
    end
    for (int i = 1; i < REG_CNT; i++) begin
      if (busy_q[i] && clr_vec[i] && !set_vec[i]) begin
        busy_cnt_d = busy_cnt_d - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy     = busy_q;
  assign busy_cnt = busy_cnt_q;

endmodule : rf_scoreboard

// File: rtl/register_file_mp.sv
// Multi-port register file with optional write-to-read bypass and a busy
// scoreboard tracking outstanding destination writes.
module register_file_mp
  import rf_defs::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int REG_ADDR   = RF_REG_ADDR,
  parameter int REG_CNT    = RF_REG_CNT,
  parameter int RD_PORTS   = 2,
  parameter int WR_PORTS   = 2,
  parameter int BYPASS     = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [RD_PORTS*REG_ADDR-1:0]   rd_addr,
  output logic [RD_PORTS*DATA_WIDTH-1:0] rd_data,
  output logic [RD_PORTS-1:0]            rd_busy,
  input  logic [WR_PORTS-1:0]            wr_en,
  input  logic [WR_PORTS*REG_ADDR-1:0]   wr_addr,
  input  logic [WR_PORTS*DATA_WIDTH-1:0] wr_data,
  input  logic                           rsv_en,
  input  logic [REG_ADDR-1:0]            rsv_addr,
  output logic [REG_ADDR:0]              busy_cnt
);

  logic [DATA_WIDTH-1:0] regs_q [REG_CNT];
  logic [DATA_WIDTH-1:0] regs_d [REG_CNT];
  logic [DATA_WIDTH-1:0] wr_val [REG_CNT];
  logic [REG_CNT-1:0]    wr_hit;
  logic [REG_CNT-1:0]    busy;

  // Per-register write decode; scanning ports upward lets the highest index win.
  always_comb begin
    for (int i = 0; i < REG_CNT; i++) begin
      wr_hit[i] = 1'b0;
      wr_val[i] = '0;
      if (i != ZERO_REG) begin
        for (int w = 0; w < WR_PORTS; w++) begin
          if (wr_en[w] && wr_addr[w*REG_ADDR +: REG_ADDR] == REG_ADDR'(i)) begin
            wr_hit[i] = 1'b1;
            wr_val[i] = wr_data[w*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
      regs_d[i] = wr_hit[i] ? wr_val[i] : regs_q[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < REG_CNT; i++) begin
      if (rst) begin
        regs_q[i] <= '0;
      end else begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Addresses 0 and beyond REG_CNT match no entry, so they read as zero and not busy.
  always_comb begin
    for (int p = 0; p < RD_PORTS; p++) begin
      rd_data[p*DATA_WIDTH +: DATA_WIDTH] = '0;
      rd_busy[p]                          = 1'b0;
      for (int i = 1; i < REG_CNT; i++) begin
        if (rd_addr[p*REG_ADDR +: REG_ADDR] == REG_ADDR'(i)) begin
          if (BYPASS != 0 && wr_hit[i]) begin
            rd_data[p*DATA_WIDTH +: DATA_WIDTH] = wr_val[i];
            rd_busy[p]                          = 1'b0;
          end else begin
            rd_data[p*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
            rd_busy[p]                          = busy[i];
          end
        end
      end
    end
  end

  rf_scoreboard #(
    .REG_ADDR (REG_ADDR),
    .REG_CNT  (REG_CNT)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .clr_vec  (wr_hit),
    .busy     (busy),
    .busy_cnt (busy_cnt)
  );

endmodule : register_file_mp

// File: tb/tb_register_file_mp.sv
// Drives a bypassing and a non-bypassing register file with the same stimulus
// and compares both against an array-based model of the register/busy state.
module tb_register_file_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data_b, rd_data_n;
  logic [1:0]  rd_busy_b, rd_busy_n;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic [5:0]  busy_cnt_b, busy_cnt_n;

  int nVectors = 0;
  int nMiscompares = 0;

  logic [31:0] mRegs [32];
  bit          mBusy [32];
  int          mCnt;

  always #5 clk = ~clk;

  register_file_mp #(.BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .busy_cnt(busy_cnt_b)
  );

  register_file_mp #(.BYPASS(0)) dut_n (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .busy_cnt(busy_cnt_n)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVectors++;
    if (obs !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelClear();
    for (int i = 0; i < 32; i++) begin
      mRegs[i] = '0;
      mBusy[i] = 0;
    end
    mCnt = 0;
  endtask

  // Drive one cycle of inputs, check combinational reads and busy_cnt before
  // the edge, then advance the model across the edge.
  task automatic applyStimulus(input logic r, input logic [1:0] we,
                               input logic [4:0] wa0, input logic [31:0] wd0,
                               input logic [4:0] wa1, input logic [31:0] wd1,
                               input logic re, input logic [4:0] ra,
                               input logic [4:0] ra0, input logic [4:0] ra1);
    logic [4:0]  wa [2];
    logic [31:0] wd [2];
    logic [4:0]  a;
    logic [31:0] expDataB, expDataN;
    logic        expBusyB, expBusyN;
    bit          written [32];
    int          cnt;

    wa[0] = wa0; wa[1] = wa1; wd[0] = wd0; wd[1] = wd1;
    rst = r; wr_en = we; wr_addr = {wa1, wa0}; wr_data = {wd1, wd0};
    rsv_en = re; rsv_addr = ra; rd_addr = {ra1, ra0};

    @(negedge clk);
    checkOutput("busy_cnt_byp", {26'd0, busy_cnt_b}, mCnt);
    checkOutput("busy_cnt_nobyp", {26'd0, busy_cnt_n}, mCnt);
    if (!r) begin
      for (int p = 0; p < 2; p++) begin
        a = (p == 0) ? ra0 : ra1;
        expDataN = (a == 0) ? 32'd0 : mRegs[a];
        expBusyN = (a == 0) ? 1'b0 : mBusy[a];
        expDataB = expDataN;
        expBusyB = expBusyN;
        for (int w = 0; w < 2; w++) begin
          if (a != 0 && we[w] && wa[w] == a) begin
            expDataB = wd[w];
            expBusyB = 1'b0;
          end
        end
        checkOutput($sformatf("rd_data_byp%0d@x%0d", p, a), rd_data_b[p*32 +: 32], expDataB);
        checkOutput($sformatf("rd_busy_byp%0d@x%0d", p, a), {31'd0, rd_busy_b[p]}, {31'd0, expBusyB});
        checkOutput($sformatf("rd_data_nobyp%0d@x%0d", p, a), rd_data_n[p*32 +: 32], expDataN);
        checkOutput($sformatf("rd_busy_nobyp%0d@x%0d", p, a), {31'd0, rd_busy_n[p]}, {31'd0, expBusyN});
      end
    end

    @(posedge clk);
    if (r) begin
      modelClear();
    end else begin
      for (int i = 0; i < 32; i++) written[i] = 0;
      for (int w = 0; w < 2; w++) begin
        if (we[w] && wa[w] != 0) begin
          mRegs[wa[w]] = wd[w];
          written[wa[w]] = 1;
        end
      end
      for (int i = 0; i < 32; i++) if (written[i]) mBusy[i] = 0;
      if (re && ra != 0) mBusy[ra] = 1;
      cnt = 0;
      for (int i = 0; i < 32; i++) cnt += int'(mBusy[i]);
      mCnt = cnt;
    end
    #1;
  endtask

  initial begin
    logic [4:0]  wa0, wa1, ra0, ra1, rsa;
    logic [31:0] wd0, wd1;

    rst = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0; rd_addr = '0;
    @(posedge clk);
    #1;
    modelClear();

    // Reset discards an earlier write.
    applyStimulus(0, 2'b01, 5, 32'hDEADBEEF, 0, 0, 0, 0, 5, 0);
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 1, 5, 5, 0);
    applyStimulus(1, 2'b11, 5, 32'h12345678, 6, 32'h9, 1, 6, 5, 6);
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 5, 6);
    checkOutput("rst_busy_cnt", {26'd0, busy_cnt_b}, 32'd0);

    // Same-address write conflict and writes to x0.
    applyStimulus(0, 2'b11, 7, 32'h11111111, 7, 32'h22222222, 0, 0, 7, 0);
    applyStimulus(0, 2'b01, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 7, 0);
    checkOutput("x7_port1_wins", rd_data_n[31:0], 32'h22222222);

    // Bypass of a same-cycle write.
    applyStimulus(0, 2'b01, 3, 32'hA5A5A5A5, 0, 0, 0, 0, 3, 3);
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 3, 0);

    // Reserve then retire x9.
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 1, 9, 9, 0);
    applyStimulus(0, 2'b10, 0, 0, 9, 32'h5, 0, 0, 9, 9);
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 9, 0);

    // Reservation and write of x4 in the same cycle keep it busy.
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 1, 4, 4, 0);
    applyStimulus(0, 2'b01, 4, 32'hCAFEF00D, 0, 0, 1, 4, 4, 0);
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 4, 0);
    checkOutput("x4_still_busy_cnt", {26'd0, busy_cnt_b}, 32'd1);

    // Fill the scoreboard, then retire two registers at once.
    applyStimulus(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i < 32; i++) begin
      applyStimulus(0, 2'b00, 0, 0, 0, 0, 1, 5'(i), 5'(i), 0);
    end
    checkOutput("cnt_full", {26'd0, busy_cnt_b}, 32'd31);
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 1, 1, 1, 2);
    checkOutput("cnt_rereserve", {26'd0, busy_cnt_b}, 32'd31);
    applyStimulus(0, 2'b11, 1, 32'h1, 2, 32'h2, 0, 0, 1, 2);
    checkOutput("cnt_dual_clear", {26'd0, busy_cnt_n}, 32'd29);
    applyStimulus(0, 2'b01, 1, 32'h3, 0, 0, 0, 0, 1, 2);
    checkOutput("cnt_nonbusy_write", {26'd0, busy_cnt_b}, 32'd29);

    // Random traffic, biased toward a few low registers to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      wa0 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      wa1 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      rsa = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      ra0 = ($urandom_range(0, 2) == 0) ? wa0 : 5'($urandom_range(0, 9));
      ra1 = ($urandom_range(0, 2) == 0) ? wa1 : 5'($urandom);
      wd0 = $urandom;
      wd1 = $urandom;
      applyStimulus(($urandom_range(0, 63) == 0), 2'($urandom), wa0, wd0, wa1, wd1,
                    1'($urandom), rsa, ra0, ra1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule : tb_register_file_mp
